// File: rtl/cp0_exc_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and bit positions.
// The pipeline controller imports the same exception codes.
package cp0_defs;

  typedef logic [3:0] execode_t;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam execode_t EXC_NONE = 4'h0;
  localparam execode_t EXC_INT  = 4'h1;
  localparam execode_t EXC_RI   = 4'ha;
  localparam execode_t EXC_OV   = 4'hc;
  localparam execode_t EXC_TR   = 4'hd;
  localparam execode_t EXC_ERET = 4'he;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;

  // Status bits that mtc0 can change: IM[15:8], EXL, IE.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  // Codes that redirect the pipeline and update EPC/Cause/Status.
  function automatic logic exc_taken(input execode_t code);
    return (code == EXC_INT) || (code == EXC_RI) ||
           (code == EXC_OV)  || (code == EXC_TR);
  endfunction

endpackage

// File: rtl/cp0_exc_if.sv
// MEM-stage / controller bundle seen by the CP0 block.
interface cp0_exc_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delay_slot;
  logic        mem_exc_ri;
  logic        mem_exc_ov;
  logic        mem_exc_tr;
  logic        mem_eret;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [5:0]  int_i;
  logic [3:0]  execode_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  modport master (
    output mem_valid, mem_pc, mem_in_delay_slot, mem_exc_ri, mem_exc_ov,
           mem_exc_tr, mem_eret, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, int_i,
    input  cp0_rdata, execode_o, epc_o, timer_int_o
  );

  modport slave (
    input  mem_valid, mem_pc, mem_in_delay_slot, mem_exc_ri, mem_exc_ov,
           mem_exc_tr, mem_eret, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, int_i,
    output cp0_rdata, execode_o, epc_o, timer_int_o
  );
endinterface

// File: rtl/cp0_exc_timer.sv
// Count/Compare registers and the sticky timer-pending flag.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_pend_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;

  // Next state: Count free-runs unless written; a Compare write clears pending.
  always_comb begin
    count_d   = count_we ? wdata : count_q + 32'd1;
    compare_d = compare_we ? wdata : compare_q;
    pend_d    = pend_q | (count_d == compare_q);
    if (compare_we) pend_d = 1'b0;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count_o      = count_q;
  assign compare_o    = compare_q;
  assign timer_pend_o = pend_q;

endmodule

// File: rtl/cp0_exc.sv
// CP0 register file and exception arbiter for the instruction in MEM.
module cp0_exc
  import cp0_defs::*;
(
  input logic        clk,
  input logic        rst,
  cp0_exc_if.slave   bus
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count, compare;
  logic        timer_pend;
  execode_t    code;
  logic        taken, irq, we_eff;

  // Prioritised exception code; interrupts need IE=1, EXL=0 and an enabled IP bit.
  always_comb begin
    irq  = status_q[ST_IE] & ~status_q[ST_EXL] & (|(cause_q[15:8] & status_q[15:8]));
    code = EXC_NONE;
    if (bus.mem_valid) begin
      if (irq)                 code = EXC_INT;
      else if (bus.mem_exc_ri) code = EXC_RI;
      else if (bus.mem_exc_ov) code = EXC_OV;
      else if (bus.mem_exc_tr) code = EXC_TR;
      else if (bus.mem_eret)   code = EXC_ERET;
    end
    taken  = exc_taken(code);
    we_eff = bus.cp0_we & ~taken;
  end

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we     (we_eff && bus.cp0_waddr == CP0_COUNT),
    .compare_we   (we_eff && bus.cp0_waddr == CP0_COMPARE),
    .wdata        (bus.cp0_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .timer_pend_o (timer_pend)
  );

  // Next Status/Cause/EPC: mtc0 first, then exception or eret side effects.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    cause_d[15:10] = bus.int_i | {timer_pend, 5'b0};
    if (we_eff && bus.cp0_waddr == CP0_STATUS) status_d = bus.cp0_wdata & STATUS_WMASK;
    if (we_eff && bus.cp0_waddr == CP0_CAUSE)  cause_d[9:8] = bus.cp0_wdata[9:8];
    if (we_eff && bus.cp0_waddr == CP0_EPC)    epc_d = bus.cp0_wdata;
    if (taken) begin
      epc_d            = bus.mem_in_delay_slot ? bus.mem_pc - 32'd4 : bus.mem_pc;
      cause_d[CA_BD]   = bus.mem_in_delay_slot;
      cause_d[6:2]     = {1'b0, code};
      status_d[ST_EXL] = 1'b1;
    end else if (code == EXC_ERET) begin
      status_d[ST_EXL] = 1'b0;
    end
  end

  // Architectural registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // mfc0 read with forwarding of a same-cycle write to the same register.
  always_comb begin
    unique case (bus.cp0_raddr)
      CP0_COUNT:   bus.cp0_rdata = count;
      CP0_COMPARE: bus.cp0_rdata = compare;
      CP0_STATUS:  bus.cp0_rdata = status_q;
      CP0_CAUSE:   bus.cp0_rdata = cause_q;
      CP0_EPC:     bus.cp0_rdata = epc_q;
      default:     bus.cp0_rdata = '0;
    endcase
    if (bus.cp0_we && bus.cp0_waddr == bus.cp0_raddr) begin
      unique case (bus.cp0_raddr)
        CP0_COUNT, CP0_COMPARE, CP0_EPC: bus.cp0_rdata = bus.cp0_wdata;
        CP0_STATUS: bus.cp0_rdata = bus.cp0_wdata & STATUS_WMASK;
        CP0_CAUSE:  bus.cp0_rdata = {cause_q[31:10], bus.cp0_wdata[9:8], cause_q[7:0]};
        default:    ;
      endcase
    end
  end

  assign bus.execode_o   = code;
  assign bus.epc_o       = (bus.cp0_we && bus.cp0_waddr == CP0_EPC) ? bus.cp0_wdata : epc_q;
  assign bus.timer_int_o = timer_pend;

endmodule

// File: tb/tb_cp0_exc.sv
// Directed and randomized bench for cp0_exc with an architectural reference model.
module tb_cp0_exc;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  cp0_exc_if bus ();
  cp0_exc dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Reference model state (architectural view).
  bit [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  bit        m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_status = 0; m_cause = 0; m_epc = 0; m_pend = 0;
  endtask

  function automatic bit [3:0] model_code();
    bit [7:0] ip, im;
    ip = m_cause[15:8];
    im = m_status[15:8];
    if (!bus.mem_valid) return 4'h0;
    if (m_status[0] && !m_status[1] && (ip & im) != 0) return 4'h1;
    if (bus.mem_exc_ri) return 4'ha;
    if (bus.mem_exc_ov) return 4'hc;
    if (bus.mem_exc_tr) return 4'hd;
    if (bus.mem_eret)   return 4'he;
    return 4'h0;
  endfunction

  function automatic bit [31:0] model_rdata();
    int a = int'(bus.cp0_raddr);
    if (bus.cp0_we && bus.cp0_waddr == bus.cp0_raddr) begin
      if (a == 9 || a == 11 || a == 14) return bus.cp0_wdata;
      if (a == 12) return bus.cp0_wdata & 32'h0000_FF03;
      if (a == 13) return (m_cause & ~32'h300) | (bus.cp0_wdata & 32'h300);
    end
    case (a)
      9:  return m_count;
      11: return m_compare;
      12: return m_status;
      13: return m_cause;
      14: return m_epc;
      default: return 0;
    endcase
  endfunction

  task automatic model_next();
    bit [3:0]  code;
    bit        tk, wr;
    bit [31:0] n_count, n_status, n_cause, n_epc;
    int        a;
    code = model_code();
    tk = (code == 4'h1 || code == 4'ha || code == 4'hc || code == 4'hd);
    wr = bus.cp0_we && !tk;
    a  = int'(bus.cp0_waddr);
    n_count  = (wr && a == 9) ? bus.cp0_wdata : m_count + 1;
    n_status = (wr && a == 12) ? (bus.cp0_wdata & 32'h0000_FF03) : m_status;
    n_cause  = (m_cause & ~32'h0000_FC00) | ({26'd0, bus.int_i | {m_pend, 5'd0}} << 10);
    if (wr && a == 13) n_cause = (n_cause & ~32'h300) | (bus.cp0_wdata & 32'h300);
    n_epc    = (wr && a == 14) ? bus.cp0_wdata : m_epc;
    if (tk) begin
      n_epc    = bus.mem_in_delay_slot ? bus.mem_pc - 4 : bus.mem_pc;
      n_cause  = (n_cause & 32'h7FFF_FF83) | ({31'd0, bus.mem_in_delay_slot} << 31)
               | ({28'd0, code} << 2);
      n_status = n_status | 32'h2;
    end else if (code == 4'he) begin
      n_status = n_status & ~32'h2;
    end
    if (wr && a == 11) m_pend = 0;
    else if (n_count == m_compare) m_pend = 1;
    if (wr && a == 11) m_compare = bus.cp0_wdata;
    m_count = n_count; m_status = n_status; m_cause = n_cause; m_epc = n_epc;
  endtask

  task automatic clr_in();
    bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_in_delay_slot = 0;
    bus.mem_exc_ri = 0; bus.mem_exc_ov = 0; bus.mem_exc_tr = 0; bus.mem_eret = 0;
    bus.cp0_we = 0; bus.cp0_waddr = 0; bus.cp0_wdata = 0; bus.cp0_raddr = 0;
    bus.int_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we = 1; bus.cp0_waddr = a; bus.cp0_wdata = d;
  endtask

  // Falling edge: compare every output with the model.
  task automatic at_neg();
    @(negedge clk);
    chk("execode", {28'd0, bus.execode_o}, {28'd0, model_code()});
    chk("epc_o", bus.epc_o, (bus.cp0_we && bus.cp0_waddr == 5'd14) ? bus.cp0_wdata : m_epc);
    chk("timer_int", {31'd0, bus.timer_int_o}, {31'd0, m_pend});
    chk("rdata", bus.cp0_rdata, model_rdata());
  endtask

  task automatic to_pos();
    model_next();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  function automatic logic [4:0] pick_addr(input int k);
    case (k)
      0: return 5'd9;
      1: return 5'd11;
      2: return 5'd12;
      3: return 5'd13;
      4: return 5'd14;
      5: return 5'd0;
      default: return 5'd31;
    endcase
  endfunction

  initial begin
    rst = 1;
    clr_in();
    model_reset();
    bus.cp0_raddr = 5'd9;
    // Reset held for three cycles: all outputs zero.
    repeat (3) begin
      @(negedge clk);
      chk("rst_execode", {28'd0, bus.execode_o}, 32'd0);
      chk("rst_epc", bus.epc_o, 32'd0);
      chk("rst_timer", {31'd0, bus.timer_int_o}, 32'd0);
      chk("rst_count", bus.cp0_rdata, 32'd0);
    end
    @(posedge clk); #1;
    rst = 0;

    bus.cp0_raddr = 5'd9;
    at_neg(); chk("count_first", bus.cp0_rdata, 32'd0); to_pos();
    bus.cp0_raddr = 5'd9;
    at_neg(); chk("count_second", bus.cp0_rdata, 32'd1); to_pos();

    // Overflow in a delay slot.
    bus.mem_valid = 1; bus.mem_exc_ov = 1; bus.mem_in_delay_slot = 1; bus.mem_pc = 32'h8000_0100;
    at_neg(); chk("ov_code", {28'd0, bus.execode_o}, 32'hc); to_pos();
    bus.cp0_raddr = 5'd14;
    at_neg(); chk("ov_epc", bus.cp0_rdata, 32'h8000_00FC); to_pos();
    bus.cp0_raddr = 5'd13;
    at_neg(); chk("ov_bd", {31'd0, bus.cp0_rdata[31]}, 32'd1);
    chk("ov_exccode", {27'd0, bus.cp0_rdata[6:2]}, 32'd12); to_pos();
    bus.cp0_raddr = 5'd12;
    at_neg(); chk("ov_exl", {31'd0, bus.cp0_rdata[1]}, 32'd1); to_pos();

    // Priority: RI over TR, then interrupt over both.
    mtc0(5'd12, 32'd0);
    at_neg(); to_pos();
    bus.mem_valid = 1; bus.mem_exc_ri = 1; bus.mem_exc_tr = 1;
    at_neg(); chk("prio_ri", {28'd0, bus.execode_o}, 32'ha); to_pos();
    mtc0(5'd12, 32'h0000_0401); bus.int_i = 6'd1;
    at_neg(); to_pos();
    bus.mem_valid = 1; bus.mem_exc_ri = 1; bus.mem_exc_tr = 1; bus.int_i = 6'd1;
    at_neg(); chk("prio_int", {28'd0, bus.execode_o}, 32'h1); to_pos();

    // EXL masks the still-pending interrupt; exception suppresses mtc0.
    bus.mem_valid = 1; bus.int_i = 6'd1;
    at_neg(); chk("exl_mask", {28'd0, bus.execode_o}, 32'h0); to_pos();
    bus.mem_valid = 1; bus.mem_exc_ri = 1; mtc0(5'd11, 32'h1234);
    at_neg(); chk("supp_code", {28'd0, bus.execode_o}, 32'ha); to_pos();
    bus.cp0_raddr = 5'd11;
    at_neg(); chk("supp_compare", bus.cp0_rdata, 32'd0); to_pos();

    // Timer: Compare=10 written while Count=5.
    mtc0(5'd9, 32'd5);
    at_neg(); to_pos();
    mtc0(5'd11, 32'd10);
    at_neg(); to_pos();
    for (int i = 6; i <= 10; i++) begin
      bus.cp0_raddr = 5'd9;
      at_neg();
      chk("tmr_count", bus.cp0_rdata, i);
      chk("tmr_int", {31'd0, bus.timer_int_o}, (i == 10) ? 32'd1 : 32'd0);
      to_pos();
    end
    mtc0(5'd11, 32'd20);
    at_neg(); chk("tmr_hold", {31'd0, bus.timer_int_o}, 32'd1); to_pos();
    at_neg(); chk("tmr_clear", {31'd0, bus.timer_int_o}, 32'd0); to_pos();

    // ERET with EPC written in the same cycle.
    bus.mem_valid = 1; bus.mem_eret = 1; mtc0(5'd14, 32'h8000_0200);
    at_neg();
    chk("eret_code", {28'd0, bus.execode_o}, 32'he);
    chk("eret_epc", bus.epc_o, 32'h8000_0200);
    to_pos();
    bus.cp0_raddr = 5'd12;
    at_neg(); chk("eret_exl", {31'd0, bus.cp0_rdata[1]}, 32'd0); to_pos();

    // Count wrap.
    mtc0(5'd9, 32'hFFFF_FFFF);
    at_neg(); to_pos();
    bus.cp0_raddr = 5'd9;
    at_neg(); chk("wrap_max", bus.cp0_rdata, 32'hFFFF_FFFF); to_pos();
    bus.cp0_raddr = 5'd9;
    at_neg(); chk("wrap_zero", bus.cp0_rdata, 32'd0); to_pos();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.mem_valid         = ($urandom_range(0, 3) != 0);
      bus.mem_pc            = $urandom & 32'hFFFF_FFFC;
      bus.mem_in_delay_slot = ($urandom_range(0, 3) == 0);
      bus.mem_exc_ri        = ($urandom_range(0, 9) == 0);
      bus.mem_exc_ov        = ($urandom_range(0, 9) == 0);
      bus.mem_exc_tr        = ($urandom_range(0, 9) == 0);
      bus.mem_eret          = ($urandom_range(0, 7) == 0);
      bus.int_i             = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      bus.cp0_raddr         = pick_addr($urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) begin
        bus.cp0_we    = 1;
        bus.cp0_waddr = pick_addr($urandom_range(0, 6));
        bus.cp0_wdata = (bus.cp0_waddr == 5'd11) ? m_count + $urandom_range(2, 30) : $urandom;
      end
      at_neg();
      to_pos();
    end

    // Asynchronous reset in the middle of operation.
    bus.cp0_raddr = 5'd9;
    rst = 1;
    #2;
    chk("arst_count", bus.cp0_rdata, 32'd0);
    chk("arst_timer", {31'd0, bus.timer_int_o}, 32'd0);
    chk("arst_epc", bus.epc_o, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    bus.cp0_raddr = 5'd9;
    at_neg(); chk("arst_count0", bus.cp0_rdata, 32'd0); to_pos();
    bus.cp0_raddr = 5'd9;
    at_neg(); chk("arst_count1", bus.cp0_rdata, 32'd1); to_pos();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
